// File: rtl/class_score_packer.sv
// Collects per-class accumulator words, requantises them to unsigned scores and
// packs each frame onto a stable output bus, with a shadow frame for overlap.
module class_score_packer #(
  parameter int unsigned BIT_SIZE    = 8,
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned ACC_WIDTH   = 20,
  parameter int unsigned SHIFT       = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [ACC_WIDTH-1:0]            s_data,
  input  logic                            s_last,
  output logic [BIT_SIZE*NUM_CLASSES-1:0] out,
  output logic                            out_valid,
  input  logic                            out_ack,
  output logic                            err_len
);

  localparam int unsigned IDX_W   = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int unsigned FRAME_W = BIT_SIZE * NUM_CLASSES;

  typedef enum logic [0:0] {COLLECT = 1'b0, WAIT = 1'b1} state_t;

  state_t              state, state_d;
  logic [IDX_W-1:0]    idx, idx_d;
  logic [FRAME_W-1:0]  shadow, shadow_d;
  logic                shadow_err, shadow_err_d;
  logic [FRAME_W-1:0]  out_d;
  logic                out_valid_d, err_len_d;

  logic signed [ACC_WIDTH-1:0] shifted;
  logic [BIT_SIZE-1:0]         score;
  logic [FRAME_W-1:0]          merged;
  logic                        xfer, last_idx, frame_end, len_bad;

  assign s_ready = rst && (state == COLLECT);

  // Requantise: arithmetic shift, then clamp to the unsigned score range.
  always_comb begin
    shifted = $signed(s_data) >>> SHIFT;
    score   = shifted[BIT_SIZE-1:0];
    if (shifted[ACC_WIDTH-1])
      score = '0;
    else if (|shifted[ACC_WIDTH-1:BIT_SIZE])
      score = '1;
  end

  // Shadow frame with the incoming score placed in the current class slice.
  always_comb begin
    merged = shadow;
    for (int k = 0; k < int'(NUM_CLASSES); k++) begin
      if (idx == IDX_W'(k))
        merged[(int'(NUM_CLASSES) - 1 - k) * int'(BIT_SIZE) +: BIT_SIZE] = score;
    end
  end

  assign xfer      = s_valid && s_ready;
  assign last_idx  = (idx == IDX_W'(NUM_CLASSES - 1));
  assign frame_end = xfer && (s_last || last_idx);
  assign len_bad   = (s_last && !last_idx) || (last_idx && !s_last);

  always_comb begin
    state_d      = state;
    idx_d        = idx;
    shadow_d     = shadow;
    shadow_err_d = shadow_err;
    out_d        = out;
    out_valid_d  = out_valid;
    err_len_d    = 1'b0;
    unique case (state)
      COLLECT: begin
        if (frame_end) begin
          if (!out_valid || out_ack) begin
            out_d       = merged;
            out_valid_d = 1'b1;
            err_len_d   = len_bad;
            shadow_d    = '0;
            idx_d       = '0;
          end else begin
            shadow_d     = merged;
            shadow_err_d = len_bad;
            state_d      = WAIT;
          end
        end else begin
          if (xfer) begin
            shadow_d = merged;
            idx_d    = idx + IDX_W'(1);
          end
          if (out_valid && out_ack)
            out_valid_d = 1'b0;
        end
      end
      WAIT: begin
        if (out_ack) begin
          out_d        = shadow;
          out_valid_d  = 1'b1;
          err_len_d    = shadow_err;
          shadow_d     = '0;
          shadow_err_d = 1'b0;
          idx_d        = '0;
          state_d      = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= COLLECT;
      idx        <= '0;
      shadow     <= '0;
      shadow_err <= 1'b0;
      out        <= '0;
      out_valid  <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      shadow     <= shadow_d;
      shadow_err <= shadow_err_d;
      out        <= out_d;
      out_valid  <= out_valid_d;
      err_len    <= err_len_d;
    end
  end

endmodule

// File: tb/tb_class_score_packer.sv
// Directed bench for class_score_packer: nominal packing, requantisation,
// length errors, back-pressure, ack/commit collision and mid-frame reset.
module tb_class_score_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [19:0] s_data;
  logic        s_last;
  logic [79:0] out;
  logic        out_valid;
  logic        out_ack;
  logic        err_len;

  int errors = 0;
  int checks = 0;

  class_score_packer #(
    .BIT_SIZE(8), .NUM_CLASSES(10), .ACC_WIDTH(20), .SHIFT(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .out      (out),
    .out_valid(out_valid),
    .out_ack  (out_ack),
    .err_len  (err_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [19:0] d, input logic last);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  initial begin
    logic [19:0] rq [10];
    rst = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; out_ack = 1'b0;
    step(); step();
    chk("rst_out", out, 80'h0);
    chk("rst_out_valid", 80'(out_valid), 80'(0));
    chk("rst_err_len", 80'(err_len), 80'(0));
    chk("rst_s_ready", 80'(s_ready), 80'(0));
    rst = 1'b1; #1;
    chk("s_ready_after_rst", 80'(s_ready), 80'(1));

    // Nominal frame: class k scores k.
    for (int k = 0; k < 10; k++) begin
      chk("nom_s_ready", 80'(s_ready), 80'(1));
      send(20'(k << 8), k == 9);
    end
    chk("nom_out", out, 80'h00010203040506070809);
    chk("nom_out_valid", 80'(out_valid), 80'(1));
    chk("nom_err_len", 80'(err_len), 80'(0));
    chk("nom_s_ready_end", 80'(s_ready), 80'(1));

    out_ack = 1'b1; step(); out_ack = 1'b0;
    chk("ack_drop_valid", 80'(out_valid), 80'(0));
    chk("ack_out_held", out, 80'h00010203040506070809);

    // Requantisation corners.
    rq = '{20'hFFED4, 20'h7FFFF, 20'h001FF, 20'h000FF, 20'h80000,
           20'h0FFFF, 20'h10000, 20'h00100, 20'h0AB00, 20'h00000};
    for (int k = 0; k < 10; k++) send(rq[k], k == 9);
    chk("rq_out", out, 80'h00FF010000FFFF01AB00);
    chk("rq_out_valid", 80'(out_valid), 80'(1));
    chk("rq_err_len", 80'(err_len), 80'(0));
    out_ack = 1'b1; step(); out_ack = 1'b0;

    // Short frame of four words.
    for (int k = 1; k <= 4; k++) send(20'(k << 8), k == 4);
    chk("short_out", out, 80'h01020304000000000000);
    chk("short_err_len", 80'(err_len), 80'(1));
    step();
    chk("short_err_pulse", 80'(err_len), 80'(0));
    chk("short_valid_held", 80'(out_valid), 80'(1));
    out_ack = 1'b1; step(); out_ack = 1'b0;

    // Frame A, then frame B under back-pressure (B has no s_last).
    for (int k = 0; k < 10; k++) send(20'h01000 + 20'(k << 8), k == 9);
    chk("a_out", out, 80'h10111213141516171819);
    chk("a_err_len", 80'(err_len), 80'(0));
    for (int k = 0; k < 10; k++) send(20'h02000 + 20'(k << 8), 1'b0);
    chk("bp_s_ready", 80'(s_ready), 80'(0));
    chk("bp_out_still_a", out, 80'h10111213141516171819);
    chk("bp_err_len", 80'(err_len), 80'(0));
    send(20'h0FF00, 1'b1);
    chk("bp_ignored_word", out, 80'h10111213141516171819);
    chk("bp_still_waiting", 80'(s_ready), 80'(0));
    out_ack = 1'b1; step(); out_ack = 1'b0;
    chk("bp_out_b", out, 80'h20212223242526272829);
    chk("bp_out_valid", 80'(out_valid), 80'(1));
    chk("bp_s_ready_back", 80'(s_ready), 80'(1));
    chk("bp_b_err_len", 80'(err_len), 80'(1));
    step();
    chk("bp_err_pulse", 80'(err_len), 80'(0));

    // Ack on the same edge as frame end: commit, no WAIT.
    for (int k = 0; k < 9; k++) send(20'h03000 + 20'(k << 8), 1'b0);
    out_ack = 1'b1;
    send(20'h03900, 1'b1);
    out_ack = 1'b0;
    chk("col_out", out, 80'h30313233343536373839);
    chk("col_out_valid", 80'(out_valid), 80'(1));
    chk("col_s_ready", 80'(s_ready), 80'(1));
    chk("col_err_len", 80'(err_len), 80'(0));
    step();
    chk("col_valid_held", 80'(out_valid), 80'(1));

    // Reset in the middle of a frame.
    for (int k = 0; k < 5; k++) send(20'h04000 + 20'(k << 8), 1'b0);
    rst = 1'b0; #1;
    chk("mid_rst_s_ready", 80'(s_ready), 80'(0));
    step();
    rst = 1'b1;
    chk("mid_rst_out", out, 80'h0);
    chk("mid_rst_out_valid", 80'(out_valid), 80'(0));
    for (int k = 0; k < 10; k++) send(20'h05000 + 20'(k << 8), k == 9);
    chk("post_rst_out", out, 80'h50515253545556575859);
    chk("post_rst_err_len", 80'(err_len), 80'(0));
    chk("post_rst_out_valid", 80'(out_valid), 80'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
